imem_responder: RTL
===================

Name: imem_responder

Overview:
Instruction-memory responder serving fetch-stage read requests over a valid/ready handshake. It accepts one word address per cycle and returns the instruction word after a fixed, parameterised latency. Responses pass through an output buffer so the fetch side can stall. It sits between the fetch stage and the instruction store. A flush discards all in-flight responses when fetch redirects on a taken branch.

Parameters:
WIDTH, 32, data/address word width (shared `WORD)
SIZE, 1024, memory depth in words; addresses are word indices (fetch STEP=1)
LATENCY, 2, cycles from request acceptance to earliest rsp_valid; legal range 1..4
DEPTH, 4, maximum outstanding requests (pipeline plus response buffer); power of 2, at least LATENCY

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; all state clears while low
req_valid  in  1  fetch presents a read request
req_ready  out  1  responder can accept a request this cycle
req_addr  in  WIDTH  word address of the instruction
rsp_valid  out  1  response word available
rsp_ready  in  1  fetch consumes the response this cycle
rsp_instr  out  WIDTH  instruction word
rsp_addr  out  WIDTH  address echoed for the response (nPC check)
rsp_err  out  1  address was out of range (req_addr >= SIZE)
flush  in  1  discard all outstanding responses (branch redirect)
ld_en  in  1  preload write strobe (test/boot)
ld_addr  in  WIDTH  preload word address
ld_data  in  WIDTH  preload data

Behaviour:
- Reset values: req_ready=0 while reset is low, then 1 from the first clk edge after release. rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0. The outstanding count is 0, buffer pointers are 0, and all pipeline valid bits are 0. Memory contents are not reset.
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- req_ready = (outstanding < DEPTH). It is a combinational function of registered state only, with no path from req_valid or rsp_ready.
- Outstanding count: +1 on accept, -1 on (rsp_valid && rsp_ready). Both in the same cycle leaves it unchanged.
- Pipeline: an accepted request enters stage 1 of a LATENCY-deep shift of {valid, addr, err}. The memory read happens in stage 1 as a registered read. On leaving stage LATENCY, the entry is written into the response buffer (DEPTH entries, circular, pointer wrap mod DEPTH).
- Latency: a request accepted at edge t shows rsp_valid at cycle t+LATENCY if the buffer was empty. Back-to-back accepts give back-to-back responses at full throughput with rsp_ready held at 1.
- Response: rsp_* are driven from the buffer head. The head holds stable while rsp_valid && !rsp_ready. It pops on rsp_valid && rsp_ready.
- Out of range: for req_addr >= SIZE, rsp_instr=0 (NOP) and rsp_err=1. There is no memory access, and ordering is preserved.
- Flush: at the edge where flush=1, all pipeline valid bits, the buffer, and the outstanding count are cleared, and rsp_valid=0 the next cycle. A request accepted in the same cycle as flush is kept (it is the redirect target), so outstanding becomes 1. Pop and flush in the same cycle: the flush wins.
- Preload: when ld_en=1, mem[ld_addr] <= ld_data. Out-of-range ld_addr is ignored. A same-cycle read of the same address returns the old data (read-before-write).
- Reset mid-operation: everything clears asynchronously and no stale response appears after release.
- Ordering: responses always return in request order. There are no reorder or drop paths except flush and reset.

Decomposition:
- Shared package/header (definitions.vh): `WORD width, `NOP encoding (0).
- Sub-module: resp_fifo, a DEPTH-entry synchronous FIFO with flush, carrying {err, addr, instr}, with push, pop, full, empty, count.
- The top holds the memory array, latency shift, and outstanding counter.

Test Plan:
- Basic read: preload mem[5]=32'h8C010004 with LATENCY=2 and rsp_ready=1; request addr 5 at edge t -> rsp_valid at t+2 with rsp_instr=32'h8C010004, rsp_addr=5, rsp_err=0.
- Streaming: preload mem[0..7]=i+100; request addr 0..7 on consecutive edges with rsp_ready=1 -> 8 consecutive responses 100..107 in order, req_ready never drops.
- Backpressure: rsp_ready=0 and issue requests -> exactly DEPTH=4 accepted and req_ready=0 after the 4th; rsp_instr stays at the first word; raise rsp_ready -> 4 responses drain in order, then req_ready=1.
- Flush: 3 outstanding requests, then assert flush with a same-cycle request to addr 20 (mem[20]=32'hDEAD0020) -> no response for the old 3; the only response is 32'hDEAD0020, LATENCY cycles later.
- Out of range: request addr SIZE (1024) -> rsp_instr=0, rsp_err=1, rsp_addr=1024; the next request to addr 1 returns normally with rsp_err=0.
- Async reset mid-stream: drop reset between edges with 2 outstanding -> rsp_valid=0 and req_ready=0 immediately; after release, no responses appear and req_ready=1 after one edge.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared word width and NOP encoding for the instruction responder
package imem_responder_pkg;

  localparam int WORD = 32;

  typedef logic [WORD-1:0] word_t;

  localparam word_t NOP = '0;

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// rtl/imem_responder_resp_fifo.sv - circular response buffer with flush, holding {err, addr, instr}
module resp_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]   store [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Flush takes priority over any push or pop in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = store[rd_ptr];

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction memory responder with stall buffer and flush
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int WIDTH   = WORD,
  parameter int SIZE    = 1024,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_instr,
  output logic [WIDTH-1:0] rsp_addr,
  output logic             rsp_err,
  input  logic             flush,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_data
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 1 + 2 * WIDTH;
  localparam int PW = LATENCY * WIDTH;
  localparam logic [WIDTH-1:0] LIMIT   = WIDTH'(SIZE);
  localparam logic [CW-1:0]    MAX_OUT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [SIZE];

  logic               ready_en;
  logic [CW-1:0]      outstanding;
  logic               accept;
  logic               pop;
  logic               req_oor;
  logic               ld_ok;
  logic [WIDTH-1:0]   rd_word;

  // Pipeline stages are packed with stage 1 in the lowest slice, so a shift is
  // simply "prepend the new entry and drop the oldest".
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [PW-1:0]      pipe_addr;
  logic [PW-1:0]      pipe_instr;
  logic [LATENCY:0]   valid_chain;
  logic [LATENCY:0]   err_chain;
  logic [PW+WIDTH-1:0] addr_chain;
  logic [PW+WIDTH-1:0] instr_chain;

  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [EW-1:0]      fifo_head;

  assign req_oor   = (req_addr >= LIMIT);
  assign ld_ok     = ld_en && (ld_addr < LIMIT);
  // Only registered state feeds req_ready, so fetch sees no combinational loop.
  assign req_ready = ready_en && (outstanding < MAX_OUT);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign rd_word   = req_oor ? WIDTH'(NOP) : mem[req_addr[AW-1:0]];

  assign valid_chain = {pipe_valid, accept};
  assign err_chain   = {pipe_err, req_oor};
  assign addr_chain  = {pipe_addr, req_addr};
  assign instr_chain = {pipe_instr, rd_word};

  // Ready rises on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Preload write and stage-1 read share an edge, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr[AW-1:0]] <= ld_data;
    pipe_instr <= instr_chain[PW-1:0];
  end

  // Control shift; a flush kills everything in flight but keeps the redirect request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      pipe_addr  <= '0;
    end else begin
      pipe_valid <= flush ? LATENCY'(accept) : valid_chain[LATENCY-1:0];
      pipe_err   <= err_chain[LATENCY-1:0];
      pipe_addr  <= addr_chain[PW-1:0];
    end
  end

  // Outstanding requests: everything accepted and not yet handed back to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else if (flush) begin
      outstanding <= CW'(accept);
    end else if (accept && !pop) begin
      outstanding <= outstanding + CW'(1);
    end else if (!accept && pop) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  assign fifo_push = pipe_valid[LATENCY-1] && !fifo_full;

  resp_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (fifo_push),
    .push_data ({pipe_err[LATENCY-1], pipe_addr[PW-1 -: WIDTH], pipe_instr[PW-1 -: WIDTH]}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign {rsp_err, rsp_addr, rsp_instr} = fifo_empty ? '0 : fifo_head;

endmodule
